// File: rtl/task_scheduler_param_pkg.sv
// Shared definitions for the task scheduler: fence encodings, FSM states and
// control-frame sizing helper.
package task_scheduler_param_pkg;

  // Encoding 3 is reserved and behaves like FenceNo.
  typedef enum logic [1:0] {
    FenceNo   = 2'd0,
    FenceAcq  = 2'd1,
    FenceRel  = 2'd2,
    FenceRsvd = 2'd3
  } fence_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitC,
    StLoad,
    StWaitIf,
    StEnd,
    StHalt,
    StSync
  } state_e;

  // Control frame layout, LSB up:
  // if_num | fence(2) | stop(1) | stop_addr | core_mask | r0_vect | r0
  function automatic int unsigned cf_width(input int unsigned ifn_w, input int unsigned ptr_w,
                                           input int unsigned num_cores,
                                           input int unsigned r0_w);
    return ifn_w + 3 + ptr_w + 2 * num_cores + num_cores * r0_w;
  endfunction

endpackage

// File: rtl/task_scheduler_param_if.sv
// Core-array bus between the scheduler (master) and the cores (slave).
interface task_scheduler_param_if #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned INSN_W    = 16,
  parameter int unsigned LOAD_TIME = 8,
  parameter int unsigned R0_W      = 8
);
  localparam int unsigned CntW = $clog2(LOAD_TIME);

  logic [NUM_CORES-1:0]      Start;
  logic [NUM_CORES-1:0]      Ready;
  logic [CntW-1:0]           Insn_Load_Counter;
  logic [INSN_W-1:0]         Insn_Data;
  logic [NUM_CORES-1:0]      Init_R0_Vect;
  logic [NUM_CORES*R0_W-1:0] Init_R0;

  modport master (
    output Start, Insn_Load_Counter, Insn_Data, Init_R0_Vect, Init_R0,
    input  Ready
  );

  modport slave (
    input  Start, Insn_Load_Counter, Insn_Data, Init_R0_Vect, Init_R0,
    output Ready
  );

endinterface

// File: rtl/task_scheduler_param_ram.sv
// Host-writable task RAM: one synchronous write port, one asynchronous read port.
module task_scheduler_param_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 128,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/task_scheduler_param.sv
// Successor task scheduler: walks control/instruction frames in the task RAM and
// streams instruction slots to the core array, with fences, halt/loop and VGA sync.
module task_scheduler_param
  import task_scheduler_param_pkg::*;
#(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned TM_DEPTH  = 64,
  parameter int unsigned INSN_W    = 16,
  parameter int unsigned LOAD_TIME = 8,
  parameter int unsigned R0_W      = 8,
  parameter int unsigned IFN_W     = 4,
  parameter bit          SYNC_EN   = 1'b1,
  localparam int unsigned PTR_W    = $clog2(TM_DEPTH),
  localparam int unsigned TM_W     = LOAD_TIME * INSN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tm_we,
  input  logic [PTR_W-1:0]  tm_waddr,
  input  logic [TM_W-1:0]   tm_wdata,
  input  logic              run_en,
  task_scheduler_param_if.master core_bus,
  input  logic              vga_end,
  output logic              vga_en,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CntW     = $clog2(LOAD_TIME);
  localparam int unsigned FenceLsb = IFN_W;
  localparam int unsigned StopBit  = IFN_W + 2;
  localparam int unsigned SaddrLsb = IFN_W + 3;
  localparam int unsigned MaskLsb  = SaddrLsb + PTR_W;
  localparam int unsigned R0vLsb   = MaskLsb + NUM_CORES;
  localparam int unsigned R0Lsb    = R0vLsb + NUM_CORES;
  localparam int unsigned CfW      = cf_width(IFN_W, PTR_W, NUM_CORES, R0_W);

  if (CfW > TM_W) begin : g_cf_too_wide
    $error("control frame does not fit in a task RAM word");
  end

  state_e                    state_q;
  logic [PTR_W-1:0]          task_pointer_q;
  logic [CntW-1:0]           cnt_q;
  logic [IFN_W-1:0]          ifs_left_q;
  logic [IFN_W-1:0]          ifn_q;
  fence_e                    fence_q;
  logic                      stop_q;
  logic [PTR_W-1:0]          stop_addr_q;
  logic [NUM_CORES-1:0]      mask_q;
  logic                      fence_pend_q;
  logic [NUM_CORES-1:0]      start_q;
  logic [CntW-1:0]           ilc_q;
  logic [INSN_W-1:0]         data_q;
  logic [NUM_CORES-1:0]      r0v_q;
  logic [NUM_CORES*R0_W-1:0] r0_q;
  logic                      vga_en_q;
  logic                      vga_end_q;
  logic                      err_q;

  logic [TM_W-1:0]                   rdata;
  logic [LOAD_TIME-1:0][INSN_W-1:0]  slots;
  logic [IFN_W-1:0]                  cf_ifn;
  logic [NUM_CORES-1:0]              cf_mask;
  logic                              all_ready;
  logic                              mask_ready;
  logic                              blocked;
  logic                              vga_rise;

  task_scheduler_param_ram #(
    .DEPTH (TM_DEPTH),
    .WIDTH (TM_W)
  ) u_ram (
    .clk   (clk),
    .we    (tm_we),
    .waddr (tm_waddr),
    .wdata (tm_wdata),
    .raddr (task_pointer_q),
    .rdata (rdata)
  );

  assign slots      = rdata;
  assign cf_ifn     = rdata[IFN_W-1:0];
  assign cf_mask    = rdata[MaskLsb +: NUM_CORES];
  assign all_ready  = &core_bus.Ready;
  assign mask_ready = (mask_q & ~core_bus.Ready) == '0;
  assign blocked    = (((fence_q == FenceAcq) || fence_pend_q) && !all_ready) || !mask_ready;
  assign vga_rise   = vga_end & ~vga_end_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      task_pointer_q <= '0;
      cnt_q          <= '0;
      ifs_left_q     <= '0;
      ifn_q          <= '0;
      fence_q        <= FenceNo;
      stop_q         <= 1'b0;
      stop_addr_q    <= '0;
      mask_q         <= '0;
      fence_pend_q   <= 1'b0;
      start_q        <= '0;
      ilc_q          <= '0;
      data_q         <= '0;
      r0v_q          <= '0;
      r0_q           <= '0;
      vga_en_q       <= 1'b0;
      vga_end_q      <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      start_q   <= '0;
      ilc_q     <= '0;
      data_q    <= '0;
      vga_en_q  <= 1'b0;
      vga_end_q <= vga_end;
      unique case (state_q)
        StIdle: begin
          if (run_en) state_q <= StFetch;
        end
        StFetch: begin
          ifn_q          <= cf_ifn;
          fence_q        <= fence_e'(rdata[FenceLsb +: 2]);
          stop_q         <= rdata[StopBit];
          stop_addr_q    <= rdata[SaddrLsb +: PTR_W];
          mask_q         <= cf_mask;
          r0v_q          <= rdata[R0vLsb +: NUM_CORES];
          r0_q           <= rdata[R0Lsb +: NUM_CORES*R0_W];
          task_pointer_q <= task_pointer_q + PTR_W'(1);
          // A task with IFs but no target cores is flagged and skipped.
          if (cf_mask == '0 && cf_ifn != '0) begin
            err_q <= 1'b1;
            ifn_q <= '0;
          end
          state_q <= StWaitC;
        end
        StWaitC: begin
          if (!blocked) begin
            if (ifn_q == '0) begin
              state_q <= StEnd;
            end else begin
              cnt_q        <= '0;
              ifs_left_q   <= ifn_q;
              fence_pend_q <= 1'b0;
              state_q      <= StLoad;
            end
          end
        end
        StLoad: begin
          start_q <= mask_q;
          ilc_q   <= cnt_q;
          data_q  <= slots[cnt_q];
          if (cnt_q == CntW'(LOAD_TIME - 1)) begin
            cnt_q          <= '0;
            task_pointer_q <= task_pointer_q + PTR_W'(1);
            ifs_left_q     <= ifs_left_q - IFN_W'(1);
            state_q        <= (ifs_left_q == IFN_W'(1)) ? StEnd : StWaitIf;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitIf: begin
          if (mask_ready) state_q <= StLoad;
        end
        StEnd: begin
          fence_pend_q <= (fence_q == FenceRel);
          if (stop_q)      state_q <= StHalt;
          else if (run_en) state_q <= StFetch;
          else             state_q <= StIdle;
        end
        StHalt: begin
          if (all_ready) begin
            vga_en_q       <= 1'b1;
            task_pointer_q <= stop_addr_q;
            state_q        <= SYNC_EN ? StSync : StFetch;
          end
        end
        StSync: begin
          // Only edges seen while already waiting here count.
          if (vga_rise) state_q <= StFetch;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_bus.Start             = start_q;
  assign core_bus.Insn_Load_Counter = ilc_q;
  assign core_bus.Insn_Data         = data_q;
  assign core_bus.Init_R0_Vect      = r0v_q;
  assign core_bus.Init_R0           = r0_q;
  assign vga_en                     = vga_en_q;
  assign busy                       = (state_q != StIdle);
  assign err                        = err_q;

endmodule

// File: tb/tb_task_scheduler_param.sv
// Directed self-checking bench for task_scheduler_param (default parameters).
module tb_task_scheduler_param;
  import task_scheduler_param_pkg::*;

  logic         clk;
  logic         reset;
  logic         tm_we;
  logic [5:0]   tm_waddr;
  logic [127:0] tm_wdata;
  logic         run_en;
  logic         vga_end;
  logic         vga_en;
  logic         busy;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  task_scheduler_param_if #(
    .NUM_CORES (4),
    .INSN_W    (16),
    .LOAD_TIME (8),
    .R0_W      (8)
  ) core_bus ();

  task_scheduler_param dut (
    .clk      (clk),
    .reset    (reset),
    .tm_we    (tm_we),
    .tm_waddr (tm_waddr),
    .tm_wdata (tm_wdata),
    .run_en   (run_en),
    .core_bus (core_bus),
    .vga_end  (vga_end),
    .vga_en   (vga_en),
    .busy     (busy),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Fields at fixed offsets for the default parameters (PTR_W=6, 4 cores, R0_W=8).
  function automatic logic [127:0] make_cf(input logic [3:0] ifn, input logic [1:0] fence,
                                           input logic stop, input logic [5:0] saddr,
                                           input logic [3:0] mask, input logic [3:0] r0v,
                                           input logic [31:0] r0);
    logic [127:0] w;
    w         = '0;
    w[3:0]    = ifn;
    w[5:4]    = fence;
    w[6]      = stop;
    w[12:7]   = saddr;
    w[16:13]  = mask;
    w[20:17]  = r0v;
    w[52:21]  = r0;
    return w;
  endfunction

  function automatic logic [127:0] make_if(input logic [15:0] base);
    logic [127:0] w;
    for (int k = 0; k < 8; k++) w[k*16 +: 16] = base + 16'(k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [5:0] addr, input logic [127:0] data);
    tm_we    = 1'b1;
    tm_waddr = addr;
    tm_wdata = data;
    tick();
    tm_we    = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    tm_we          = 1'b0;
    run_en         = 1'b0;
    vga_end        = 1'b0;
    core_bus.Ready = 4'b1111;
    for (int a = 0; a < 8; a++) write_word(6'(a), '0);
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_run();
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
  endtask

  task automatic wait_start(input logic [3:0] m, input int max_cyc, output bit found);
    found = 1'b0;
    for (int c = 0; c < max_cyc && !found; c++) begin
      @(negedge clk);
      if (core_bus.Start == m) found = 1'b1;
    end
  endtask

  initial begin
    int           n_start;
    bit           found;
    logic [15:0]  exp_data;
    state_e       prev_state;

    tm_waddr = '0;
    tm_wdata = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_start", core_bus.Start, 0);
    check_eq("rst_ilc", core_bus.Insn_Load_Counter, 0);
    check_eq("rst_data", core_bus.Insn_Data, 0);
    check_eq("rst_r0v", core_bus.Init_R0_Vect, 0);
    check_eq("rst_r0", core_bus.Init_R0, 0);
    check_eq("rst_vga_en", vga_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ptr", dut.task_pointer_q, 0);

    // 1: two IFs to cores 0/1
    write_word(6'd0, make_cf(4'd2, 2'd0, 1'b0, 6'd0, 4'b0011, 4'b0, 32'h0));
    write_word(6'd1, make_if(16'hA000));
    write_word(6'd2, make_if(16'hB000));
    pulse_run();
    n_start = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (core_bus.Start != 4'b0000) begin
        exp_data = (n_start < 8) ? 16'hA000 + 16'(n_start) : 16'hB000 + 16'(n_start - 8);
        check_eq("t1_start", core_bus.Start, 4'b0011);
        check_eq("t1_ilc", core_bus.Insn_Load_Counter, n_start % 8);
        check_eq("t1_data", core_bus.Insn_Data, exp_data);
        n_start++;
      end
    end
    check_eq("t1_nstart", n_start, 16);
    check_eq("t1_ptr", dut.task_pointer_q, 3);
    check_eq("t1_busy", busy, 0);

    // 2: ACQ fence waits for all cores idle
    do_reset();
    core_bus.Ready = 4'b1110;
    write_word(6'd0, make_cf(4'd1, 2'd1, 1'b0, 6'd0, 4'b0001, 4'b0, 32'h0));
    write_word(6'd1, make_if(16'hC000));
    pulse_run();
    n_start = 0;
    repeat (8) begin
      @(negedge clk);
      if (core_bus.Start != 4'b0000) n_start++;
    end
    check_eq("t2_blocked", n_start, 0);
    check_eq("t2_busy", busy, 1);
    tick();
    core_bus.Ready = 4'b1111;
    @(negedge clk);
    check_eq("t2_wait1", core_bus.Start, 4'b0000);
    @(negedge clk);
    check_eq("t2_wait2", core_bus.Start, 4'b0000);
    @(negedge clk);
    check_eq("t2_first", core_bus.Start, 4'b0001);
    check_eq("t2_first_data", core_bus.Insn_Data, 16'hC000);
    repeat (12) @(negedge clk);
    check_eq("t2_done", busy, 0);
    check_eq("t2_ptr", dut.task_pointer_q, 2);

    // 3: REL task holds the next task until core 0 is idle again
    do_reset();
    write_word(6'd0, make_cf(4'd1, 2'd2, 1'b0, 6'd0, 4'b0001, 4'b0, 32'h0));
    write_word(6'd1, make_if(16'hD000));
    write_word(6'd2, make_cf(4'd1, 2'd0, 1'b0, 6'd0, 4'b0010, 4'b0, 32'h0));
    write_word(6'd3, make_if(16'hE000));
    run_en = 1'b1;
    wait_start(4'b0001, 20, found);
    check_eq("t3_first_start", found, 1);
    core_bus.Ready = 4'b1110;
    n_start = 0;
    repeat (25) begin
      @(negedge clk);
      if (core_bus.Start == 4'b0010) n_start++;
    end
    check_eq("t3_held", n_start, 0);
    check_eq("t3_busy", busy, 1);
    core_bus.Ready = 4'b1111;
    run_en         = 1'b0;
    wait_start(4'b0010, 10, found);
    check_eq("t3_released", found, 1);
    check_eq("t3_data", core_bus.Insn_Data, 16'hE000);

    // 4: halt at word 5, loop to 0, sync to VGA
    do_reset();
    write_word(6'd0, make_cf(4'd4, 2'd0, 1'b0, 6'd0, 4'b0001, 4'b0, 32'h0));
    for (int a = 1; a <= 4; a++) write_word(6'(a), make_if(16'h1000 * 16'(a)));
    write_word(6'd5, make_cf(4'd0, 2'd0, 1'b1, 6'd0, 4'b0000, 4'b0, 32'h0));
    run_en     = 1'b1;
    found      = 1'b0;
    prev_state = StIdle;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (vga_en) found = 1'b1;
      else        prev_state = dut.state_q;
    end
    check_eq("t4_vga_en", found, 1);
    check_eq("t4_from_halt", prev_state, StHalt);
    check_eq("t4_ptr", dut.task_pointer_q, 0);
    check_eq("t4_sync", dut.state_q, StSync);
    run_en = 1'b0;
    @(negedge clk);
    check_eq("t4_pulse", vga_en, 0);
    repeat (3) @(negedge clk);
    check_eq("t4_still_sync", dut.state_q, StSync);
    vga_end = 1'b1;
    @(negedge clk);
    check_eq("t4_fetch", dut.state_q, StFetch);
    vga_end = 1'b0;

    // 5: skipped tasks still load R0; empty mask with IFs flags err
    do_reset();
    write_word(6'd0, make_cf(4'd0, 2'd0, 1'b0, 6'd0, 4'b0000, 4'b1010, 32'h44332211));
    write_word(6'd1, make_cf(4'd3, 2'd0, 1'b0, 6'd0, 4'b0000, 4'b0101, 32'h88776655));
    pulse_run();
    n_start = 0;
    repeat (6) begin
      @(negedge clk);
      if (core_bus.Start != 4'b0000) n_start++;
    end
    check_eq("t5a_nstart", n_start, 0);
    check_eq("t5a_r0v", core_bus.Init_R0_Vect, 4'b1010);
    check_eq("t5a_r0", core_bus.Init_R0, 32'h44332211);
    check_eq("t5a_err", err, 0);
    check_eq("t5a_ptr", dut.task_pointer_q, 1);
    pulse_run();
    n_start = 0;
    repeat (6) begin
      @(negedge clk);
      if (core_bus.Start != 4'b0000) n_start++;
    end
    check_eq("t5b_nstart", n_start, 0);
    check_eq("t5b_err", err, 1);
    check_eq("t5b_ptr", dut.task_pointer_q, 2);
    check_eq("t5b_r0v", core_bus.Init_R0_Vect, 4'b0101);
    check_eq("t5b_busy", busy, 0);

    // 6: asynchronous reset in the middle of a load
    do_reset();
    write_word(6'd0, make_cf(4'd1, 2'd0, 1'b0, 6'd0, 4'b1111, 4'b1111, 32'hAABBCCDD));
    write_word(6'd1, make_if(16'hF000));
    pulse_run();
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (core_bus.Start != 4'b0000 && core_bus.Insn_Load_Counter == 3'd3) found = 1'b1;
    end
    check_eq("t6_mid_load", found, 1);
    check_eq("t6_r0_loaded", core_bus.Init_R0, 32'hAABBCCDD);
    reset = 1'b1;
    #1;
    check_eq("t6_start", core_bus.Start, 0);
    check_eq("t6_ilc", core_bus.Insn_Load_Counter, 0);
    check_eq("t6_data", core_bus.Insn_Data, 0);
    check_eq("t6_r0", core_bus.Init_R0, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_ptr", dut.task_pointer_q, 0);
    tick();
    reset = 1'b0;
    tick();
    pulse_run();
    wait_start(4'b1111, 10, found);
    check_eq("t6_restart", found, 1);
    check_eq("t6_restart_ilc", core_bus.Insn_Load_Counter, 0);
    check_eq("t6_restart_data", core_bus.Insn_Data, 16'hF000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
